npl_mem_responder: RTL and testbench
====================================

Name: npl_mem_responder

Overview:
- Synthesizable memory responder for the non-pipelined RISC: the target end of the CPU's instruction-fetch / LD / STR memory interface.
- Accepts one read or write request at a time over a valid/ready handshake, inserts a programmable number of wait states, then returns a response over a second valid/ready handshake.
- Sits between the CPU core and the unified program/data memory array (32-bit words, 12-bit word address).

Parameters:
- WIDTH, 32, data word width in bits.
- ADDRSIZE, 12, request address width in bits.
- MEMSIZE, 18, number of implemented words; addresses 0..MEMSIZE-1 are valid.
- WAIT_CYCLES, 2, wait states between request accept and response valid (0..15 legal).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = write (STR), 0 = read (fetch/LD).
- req_addr  input  ADDRSIZE  word address.
- req_wdata  input  WIDTH  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  WIDTH  read data; for writes, echo of the written data.
- rsp_we  output  1  echo of req_we for this response.
- rsp_err  output  1  address out of range (addr >= MEMSIZE).

Behaviour:
- Reset (sampled at clk edge with reset==0): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_we=0, rsp_err=0, wait counter=0.
- Reset does not clear memory contents.
- Reset mid-transaction aborts it: no response is produced. A pending write is not performed unless it was already committed on an earlier edge.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready at edge T, latch addr/we/wdata, set req_ready=0. Go to WAIT if WAIT_CYCLES>0, loading counter=WAIT_CYCLES-1; otherwise go to EXEC.
  - WAIT: counter decrements each cycle; go to EXEC on the edge where counter==0.
  - EXEC (one cycle): commit the access on this edge, load the response registers, set rsp_valid=1, go to RESP.
  - RESP: hold rsp_valid and all rsp_* stable until rsp_valid&rsp_ready, then clear rsp_valid, go to IDLE, req_ready=1.
- Latency: rsp_valid first high in cycle T+2+WAIT_CYCLES. req_ready returns high the cycle after the response handshake.
- Only one outstanding request. Peak throughput is one transaction per 3+WAIT_CYCLES cycles.
- Read in range: rsp_rdata = MEM[addr], rsp_err=0.
- Write in range: MEM[addr] = wdata at the EXEC edge, rsp_rdata = wdata, rsp_err=0.
- Out-of-range (addr >= MEMSIZE, full ADDRSIZE compare, no wrap): rsp_err=1, rsp_rdata=0, and memory is never modified.
- rsp_ready held high continuously: handshake completes in the first RESP cycle.
- req_valid while req_ready=0 is ignored and not queued. The requester must hold the request until accepted.
- Read-after-write to the same address returns the new data.
- req_* changes after acceptance have no effect on the in-flight transaction.
- X on req_valid or rsp_ready is not tolerated; the bench drives them defined at all times.

Test Plan:
- Reset then write: reset=0 for 2 cycles, then reset=1; expect req_ready=1, rsp_valid=0. Write addr 5, data 0xDEADBEEF accepted at T (WAIT_CYCLES=2) -> rsp_valid at T+4, rsp_we=1, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Read-after-write: read addr 5 -> rsp_rdata=0xDEADBEEF after 4 cycles. Read addr 17 after writing 0x00000007 -> 0x00000007.
- Out of range: write addr 18, data 0x12345678 -> rsp_err=1, rsp_rdata=0. A subsequent read of addr 18 -> rsp_err=1. A read of addr 0xFFF -> rsp_err=1, no wrap to addr 0.
- Backpressure: hold rsp_ready=0 for 5 cycles during a read of addr 5 -> rsp_valid and rsp_rdata stable for all 5 cycles. req_ready=0 throughout; a second req_valid during this window is not accepted. rsp_ready=1 -> req_ready=1 on the next cycle.
- Zero wait (WAIT_CYCLES=0): accept at T -> rsp_valid at T+2. Back-to-back requests with rsp_ready=1 are accepted at T, T+3, T+6.
- Reset mid-operation: accept a write of 0xAAAA5555 to addr 3, where addr 3 previously held 0x11111111, and assert reset=0 during WAIT -> no rsp_valid. A later read of addr 3 returns 0x11111111.

Source files
------------

// File: rtl/npl_mem_responder.sv
// Memory responder for the non-pipelined RISC: accepts one fetch/LD/STR request at a time,
// waits a fixed number of cycles, then presents a held response until it is accepted.
module npl_mem_responder #(
    parameter int WIDTH       = 32,
    parameter int ADDRSIZE    = 12,
    parameter int MEMSIZE     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDRSIZE-1:0] req_addr,
    input  logic [WIDTH-1:0]    req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_rdata,
    output logic                rsp_we,
    output logic                rsp_err
);

    localparam int IDXW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [ADDRSIZE:0] MEM_LIMIT = (ADDRSIZE + 1)'(MEMSIZE);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic [ADDRSIZE-1:0] addr_reg;
    logic                we_reg;
    logic [WIDTH-1:0]    wdata_reg;
    logic [WIDTH-1:0]    rdata_reg;
    logic                rsp_we_reg;
    logic                rsp_err_reg;
    logic [WIDTH-1:0]    mem [0:MEMSIZE-1];

    logic                accept;
    logic                in_range;
    logic                commit_write;
    logic [IDXW-1:0]     mem_idx;

    assign accept       = (state_reg == IDLE) && req_valid;
    // Full-width compare so that addresses past the array never alias onto low words.
    assign in_range     = ({1'b0, addr_reg} < MEM_LIMIT);
    assign mem_idx      = addr_reg[IDXW-1:0];
    assign commit_write = reset && (state_reg == EXEC) && we_reg && in_range;

    // State register plus response datapath.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rdata_reg   <= '0;
            rsp_we_reg  <= 1'b0;
            rsp_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == EXEC) begin
                rsp_we_reg  <= we_reg;
                rsp_err_reg <= !in_range;
                if (!in_range) begin
                    rdata_reg <= '0;
                end else if (we_reg) begin
                    rdata_reg <= wdata_reg;
                end else begin
                    rdata_reg <= mem[mem_idx];
                end
            end
        end
    end

    // Request capture; later changes on req_* cannot reach the in-flight access.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_reg  <= req_addr;
            we_reg    <= req_we;
            wdata_reg <= req_wdata;
        end
    end

    // Memory array is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            mem[mem_idx] <= wdata_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end else begin
                        state_next = EXEC;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = EXEC;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == IDLE);
        rsp_valid = (state_reg == RESP);
        rsp_rdata = rdata_reg;
        rsp_we    = rsp_we_reg;
        rsp_err   = rsp_err_reg;
    end

endmodule

// File: tb/tb_npl_mem_responder.sv
// Bench for npl_mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, a transaction-level
// model checked every cycle, and directed transactions with hand-computed expectations.
module tb_npl_mem_responder;

    localparam int MEMSIZE = 18;

    logic        clk;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [11:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_we    [2];
    logic        rsp_err   [2];

    int checks = 0;
    int errors = 0;

    npl_mem_responder #(.WIDTH(32), .ADDRSIZE(12), .MEMSIZE(MEMSIZE), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_we(rsp_we[0]), .rsp_err(rsp_err[0])
    );

    npl_mem_responder #(.WIDTH(32), .ADDRSIZE(12), .MEMSIZE(MEMSIZE), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_we(rsp_we[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction model: a request taken at edge k yields its response after edge k+1+W,
    // which stays up until an edge that sees rsp_ready.
    bit          m_init = 1'b0;
    int          m_edge = 0;
    bit          m_busy  [2];
    bit          m_rv    [2];
    int          m_acc   [2];
    logic        m_lwe   [2];
    logic [11:0] m_laddr [2];
    logic [31:0] m_lwd   [2];
    logic [31:0] m_rd    [2];
    logic        m_we    [2];
    logic        m_err   [2];
    logic [31:0] mm      [2][4096];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_busy[d] <= 1'b0;
                m_rv[d]   <= 1'b0;
                m_rd[d]   <= '0;
                m_we[d]   <= 1'b0;
                m_err[d]  <= 1'b0;
            end else if (m_rv[d]) begin
                if (rsp_ready[d]) begin
                    m_rv[d]   <= 1'b0;
                    m_busy[d] <= 1'b0;
                end
            end else if (m_busy[d]) begin
                if (m_edge == m_acc[d] + 1 + wc(d)) begin
                    m_rv[d] <= 1'b1;
                    m_we[d] <= m_lwe[d];
                    if (int'(m_laddr[d]) >= MEMSIZE) begin
                        m_err[d] <= 1'b1;
                        m_rd[d]  <= '0;
                    end else if (m_lwe[d]) begin
                        mm[d][m_laddr[d]] <= m_lwd[d];
                        m_rd[d]  <= m_lwd[d];
                        m_err[d] <= 1'b0;
                    end else begin
                        m_rd[d]  <= mm[d][m_laddr[d]];
                        m_err[d] <= 1'b0;
                    end
                end
            end else if (req_valid[d]) begin
                m_busy[d]  <= 1'b1;
                m_acc[d]   <= m_edge;
                m_lwe[d]   <= req_we[d];
                m_laddr[d] <= req_addr[d];
                m_lwd[d]   <= req_wdata[d];
            end
        end
        if (!reset) m_init <= 1'b1;
        m_edge <= m_edge + 1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d model req_ready", d), 32'(req_ready[d]), 32'(!m_busy[d]));
                check($sformatf("dut%0d model rsp_valid", d), 32'(rsp_valid[d]), 32'(m_rv[d]));
                if (m_rv[d]) begin
                    check($sformatf("dut%0d model rsp_rdata", d), rsp_rdata[d], m_rd[d]);
                    check($sformatf("dut%0d model rsp_we", d), 32'(rsp_we[d]), 32'(m_we[d]));
                    check($sformatf("dut%0d model rsp_err", d), 32'(rsp_err[d]), 32'(m_err[d]));
                end
            end
        end
    end

    task automatic send(input int d, input logic we, input logic [11:0] addr,
                        input logic [31:0] wd, output time t_acc);
        bit ok;
        ok    = 1'b0;
        t_acc = 0;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[d] === 1'b1) begin
                @(posedge clk);
                t_acc = $time;
                ok    = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL dut%0d accept: request not taken within 20 cycles", d);
        end
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~addr;
        req_wdata[d] = ~wd;
    endtask

    task automatic await_rsp(input int d, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[d] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL dut%0d rsp_timeout: no rsp_valid within 40 cycles", d);
        end
    endtask

    task automatic txn(input int d, input logic we, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag,
                       output time t_acc);
        int lat;
        send(d, we, addr, wd, t_acc);
        await_rsp(d, lat);
        check({tag, " latency"}, 32'(lat), 32'(2 + wc(d)));
        check({tag, " rdata"}, rsp_rdata[d], exp_rd);
        check({tag, " we"}, 32'(rsp_we[d]), 32'(we));
        check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    time t0, t1, t2;
    int  lat;

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("dut%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("dut%0d reset rsp_rdata", d), rsp_rdata[d], 32'h0);
            check($sformatf("dut%0d reset rsp_we", d), 32'(rsp_we[d]), 32'd0);
            check($sformatf("dut%0d reset rsp_err", d), 32'(rsp_err[d]), 32'd0);
        end
        @(posedge clk);
        #1;

        // WAIT_CYCLES=2: write/read, range edges
        txn(0, 1'b1, 12'd5,   32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "w2 wr5",    t0);
        txn(0, 1'b0, 12'd5,   32'h0,        32'hDEADBEEF, 1'b0, "w2 rd5",    t0);
        txn(0, 1'b1, 12'd17,  32'h00000007, 32'h00000007, 1'b0, "w2 wr17",   t0);
        txn(0, 1'b0, 12'd17,  32'h0,        32'h00000007, 1'b0, "w2 rd17",   t0);
        txn(0, 1'b1, 12'd0,   32'hCAFEF00D, 32'hCAFEF00D, 1'b0, "w2 wr0",    t0);
        txn(0, 1'b1, 12'd18,  32'h12345678, 32'h0,        1'b1, "w2 wr18",   t0);
        txn(0, 1'b0, 12'd18,  32'h0,        32'h0,        1'b1, "w2 rd18",   t0);
        txn(0, 1'b0, 12'hFFF, 32'h0,        32'h0,        1'b1, "w2 rdFFF",  t0);
        txn(0, 1'b0, 12'd0,   32'h0,        32'hCAFEF00D, 1'b0, "w2 rd0",    t0);

        // Backpressure: response held five cycles, a competing request is ignored
        rsp_ready[0] = 1'b0;
        send(0, 1'b0, 12'd5, 32'h0, t0);
        await_rsp(0, lat);
        check("w2 bp latency", 32'(lat), 32'd4);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 12'd9;
        req_wdata[0] = 32'h00000055;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("w2 bp rsp_valid c%0d", i), 32'(rsp_valid[0]), 32'd1);
            check($sformatf("w2 bp rsp_rdata c%0d", i), rsp_rdata[0], 32'hDEADBEEF);
            check($sformatf("w2 bp req_ready c%0d", i), 32'(req_ready[0]), 32'd0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("w2 bp release req_ready", 32'(req_ready[0]), 32'd1);
        check("w2 bp release rsp_valid", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk);
        #1;

        // WAIT_CYCLES=0: two-cycle latency, acceptance every three cycles
        txn(1, 1'b1, 12'd2, 32'h0BADF00D, 32'h0BADF00D, 1'b0, "w0 wr2", t0);
        txn(1, 1'b0, 12'd2, 32'h0,        32'h0BADF00D, 1'b0, "w0 rd2", t1);
        txn(1, 1'b1, 12'd4, 32'h00C0FFEE, 32'h00C0FFEE, 1'b0, "w0 wr4", t2);
        check("w0 b2b spacing 1", 32'((t1 - t0) / 10), 32'd3);
        check("w0 b2b spacing 2", 32'((t2 - t1) / 10), 32'd3);

        // Reset during WAIT aborts the write and produces no response
        txn(0, 1'b1, 12'd3, 32'h11111111, 32'h11111111, 1'b0, "w2 wr3 init", t0);
        send(0, 1'b1, 12'd3, 32'hAAAA5555, t0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("w2 abort rsp_valid c%0d", i), 32'(rsp_valid[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        txn(0, 1'b0, 12'd3, 32'h0, 32'h11111111, 1'b0, "w2 rd3 after abort", t0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
